// File: rtl/bank_read_scheduler.sv
// Read-port to 2x2 X/Y bank scheduler for the vector register file.
// Per-bank round-robin issue with 1-cycle bank latency response routing.
module bank_read_scheduler #(
    parameter int PORT_NUM     = 2,
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 6,
    parameter int ADDR_X_SIZE  = 1,
    parameter int ADDR_X_WIDTH = 1,
    parameter int ADDR_Y_SIZE  = 16,
    parameter int ADDR_Y_WIDTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [PORT_NUM-1:0]                  rd_req_valid,
    output logic [PORT_NUM-1:0]                  rd_req_ready,
    input  logic [PORT_NUM-1:0][ADDR_WIDTH-1:0]  rd_req_addr,
    output logic [3:0]                           bank_rd_en,
    output logic [3:0][ADDR_Y_WIDTH-1:0]         bank_rd_addr,
    input  logic [3:0][DATA_WIDTH-1:0]           bank_rd_data,
    output logic [PORT_NUM-1:0]                  rd_rsp_valid,
    output logic [PORT_NUM-1:0][DATA_WIDTH-1:0]  rd_rsp_data
);

    localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    function automatic logic [1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
        logic [31:0] x;
        logic [31:0] y;
        x = 32'(a[ADDR_X_WIDTH-1:0]);
        y = 32'(a[ADDR_WIDTH-1:ADDR_X_WIDTH]);
        return {x >= 32'(ADDR_X_SIZE), y >= 32'(ADDR_Y_SIZE)};
    endfunction

    logic [PORT_NUM-1:0]                    pend_vld;
    logic [PORT_NUM-1:0][1:0]               pend_bank;
    logic [PORT_NUM-1:0][ADDR_Y_WIDTH-1:0]  pend_row;
    logic [3:0][PW-1:0]                     rr;
    logic [PORT_NUM-1:0]                    rsp_vld_q;
    logic [PORT_NUM-1:0][1:0]               rsp_bank_q;

    logic [PORT_NUM-1:0]                    gnt;
    logic [PORT_NUM-1:0]                    acc;
    logic [3:0][PW-1:0]                     win;
    logic [3:0][PW-1:0]                     rr_nxt;
    logic [PW-1:0]                          idx;

    // Search each bank's pending ports starting at its round-robin pointer.
    always_comb begin
        gnt          = '0;
        win          = '0;
        idx          = '0;
        bank_rd_en   = '0;
        bank_rd_addr = '0;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < PORT_NUM; k++) begin
                idx = PW'((int'(rr[b]) + k) % PORT_NUM);
                if (!bank_rd_en[b] && pend_vld[idx] &&
                    pend_bank[idx] == 2'(b)) begin
                    bank_rd_en[b]   = 1'b1;
                    bank_rd_addr[b] = pend_row[idx];
                    win[b]          = idx;
                    gnt[idx]        = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rr_nxt = '0;
        for (int b = 0; b < 4; b++) begin
            rr_nxt[b] = (win[b] == PW'(PORT_NUM - 1)) ? '0 : win[b] + 1'b1;
        end
    end

    assign rd_req_ready = ~pend_vld | gnt;
    assign acc          = rd_req_valid & rd_req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld   <= '0;
            pend_bank  <= '0;
            pend_row   <= '0;
            rr         <= '0;
            rsp_vld_q  <= '0;
            rsp_bank_q <= '0;
        end else begin
            for (int p = 0; p < PORT_NUM; p++) begin
                if (acc[p]) begin
                    pend_vld[p]  <= 1'b1;
                    pend_bank[p] <= bank_of(rd_req_addr[p]);
                    pend_row[p]  <= rd_req_addr[p][ADDR_X_WIDTH +: ADDR_Y_WIDTH];
                end else if (gnt[p]) begin
                    pend_vld[p] <= 1'b0;
                end
                if (gnt[p]) begin
                    rsp_bank_q[p] <= pend_bank[p];
                end
            end
            rsp_vld_q <= gnt;
            for (int b = 0; b < 4; b++) begin
                if (bank_rd_en[b]) begin
                    rr[b] <= rr_nxt[b];
                end
            end
        end
    end

    assign rd_rsp_valid = rsp_vld_q;

    always_comb begin
        rd_rsp_data = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            if (rsp_vld_q[p]) begin
                rd_rsp_data[p] = bank_rd_data[rsp_bank_q[p]];
            end
        end
    end

endmodule

// File: tb/tb_bank_read_scheduler.sv
// Bench for bank_read_scheduler: queue-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_bank_read_scheduler;

    localparam int PN = 2;
    localparam int DW = 64;
    localparam int AW = 6;
    localparam int XS = 1;
    localparam int XW = 1;
    localparam int YS = 16;
    localparam int YW = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [PN-1:0]          rd_req_valid;
    logic [PN-1:0]          rd_req_ready;
    logic [PN-1:0][AW-1:0]  rd_req_addr;
    logic [3:0]             bank_rd_en;
    logic [3:0][YW-1:0]     bank_rd_addr;
    logic [3:0][DW-1:0]     bank_rd_data;
    logic [PN-1:0]          rd_rsp_valid;
    logic [PN-1:0][DW-1:0]  rd_rsp_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bank_read_scheduler #(
        .PORT_NUM(PN), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .ADDR_X_SIZE(XS), .ADDR_X_WIDTH(XW),
        .ADDR_Y_SIZE(YS), .ADDR_Y_WIDTH(YW)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr),
        .bank_rd_en(bank_rd_en), .bank_rd_addr(bank_rd_addr),
        .bank_rd_data(bank_rd_data),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data)
    );

    function automatic logic [63:0] memval(int b, int r);
        return 64'hAAAA_0000_0000_0000 + 64'(b * 256 + r);
    endfunction

    function automatic int bank_of(int a);
        int x;
        int y;
        x = a % (1 << XW);
        y = a >> XW;
        return ((x >= XS) ? 2 : 0) + ((y >= YS) ? 1 : 0);
    endfunction

    function automatic int row_of(int a);
        return (a >> XW) % (1 << YW);
    endfunction

    // Bank memories: content identifies bank and row, garbage when not read.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            bank_rd_data[b] <= bank_rd_en[b] ? memval(b, int'(bank_rd_addr[b]))
                                             : 64'hDEAD_0000_0000_0000 + 64'(b);
        end
    end

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: one pending request per port, per-bank pointer.
    bit          mpend[PN]     = '{default: 0};
    int          maddr[PN]     = '{default: 0};
    bit          mrsp[PN]      = '{default: 0};
    int          mrsp_bank[PN] = '{default: 0};
    int          mrsp_row[PN]  = '{default: 0};
    int          mrr[4]        = '{default: 0};

    int          exp_win[4];
    int          exp_row[4];
    bit          exp_en[4];
    bit          exp_gnt[PN];
    bit          exp_ready[PN];
    logic [63:0] exp_rsp_data[PN];

    always_comb begin
        for (int p = 0; p < PN; p++) exp_gnt[p] = 1'b0;
        for (int b = 0; b < 4; b++) begin
            int best;
            best       = PN;
            exp_win[b] = -1;
            exp_row[b] = 0;
            exp_en[b]  = 1'b0;
            for (int p = 0; p < PN; p++) begin
                if (mpend[p] && bank_of(maddr[p]) == b &&
                    ((p - mrr[b] + PN) % PN) < best) begin
                    best       = (p - mrr[b] + PN) % PN;
                    exp_win[b] = p;
                end
            end
            if (exp_win[b] >= 0) begin
                exp_en[b]           = 1'b1;
                exp_row[b]          = row_of(maddr[exp_win[b]]);
                exp_gnt[exp_win[b]] = 1'b1;
            end
        end
        for (int p = 0; p < PN; p++) begin
            exp_ready[p]    = !mpend[p] || exp_gnt[p];
            exp_rsp_data[p] = mrsp[p] ? memval(mrsp_bank[p], mrsp_row[p]) : 64'h0;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < PN; p++) begin
                mpend[p] <= 1'b0;
                mrsp[p]  <= 1'b0;
            end
            for (int b = 0; b < 4; b++) mrr[b] <= 0;
        end else begin
            for (int p = 0; p < PN; p++) begin
                mrsp[p] <= exp_gnt[p];
                if (exp_gnt[p]) begin
                    mrsp_bank[p] <= bank_of(maddr[p]);
                    mrsp_row[p]  <= row_of(maddr[p]);
                end
                if (rd_req_valid[p] && exp_ready[p]) begin
                    mpend[p] <= 1'b1;
                    maddr[p] <= int'(rd_req_addr[p]);
                end else if (exp_gnt[p]) begin
                    mpend[p] <= 1'b0;
                end
            end
            for (int b = 0; b < 4; b++) begin
                if (exp_win[b] >= 0) mrr[b] <= (exp_win[b] + 1) % PN;
            end
        end
    end

    always @(negedge clk) begin
        for (int p = 0; p < PN; p++) begin
            check($sformatf("m_ready%0d", p), 64'(rd_req_ready[p]), 64'(exp_ready[p]));
            check($sformatf("m_rspv%0d", p), 64'(rd_rsp_valid[p]), 64'(mrsp[p]));
            check($sformatf("m_rspd%0d", p), rd_rsp_data[p], exp_rsp_data[p]);
        end
        for (int b = 0; b < 4; b++) begin
            check($sformatf("m_en%0d", b), 64'(bank_rd_en[b]), 64'(exp_en[b]));
            check($sformatf("m_addr%0d", b), 64'(bank_rd_addr[b]), 64'(exp_row[b]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Both ports hit bank 0 with the pointer at 0: port0 then port1.
    task automatic conflict(string tag);
        rd_req_valid   = 2'b11;
        rd_req_addr[0] = 6'h04;
        rd_req_addr[1] = 6'h04;
        step();
        rd_req_valid = 2'b00;
        #1;
        check({tag, "_en1"}, 64'(bank_rd_en), 64'h1);
        check({tag, "_rdy1"}, 64'(rd_req_ready), 64'h1);
        step();
        #1;
        check({tag, "_en2"}, 64'(bank_rd_en), 64'h1);
        check({tag, "_rdy2"}, 64'(rd_req_ready), 64'h3);
        check({tag, "_rsp2"}, 64'(rd_rsp_valid), 64'h1);
        step();
        #1;
        check({tag, "_rsp3"}, 64'(rd_rsp_valid), 64'h2);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int c0;
        int c1;
        rd_req_valid = '0;
        rd_req_addr  = '0;
        repeat (2) step();
        #1;
        check("rst_ready", 64'(rd_req_ready), 64'h3);
        check("rst_en", 64'(bank_rd_en), 64'h0);
        check("rst_rspv", 64'(rd_rsp_valid), 64'h0);
        check("rst_data", rd_rsp_data[0] | rd_rsp_data[1], 64'h0);
        rst = 1'b0;
        step();

        // Single read on port 0
        rd_req_valid   = 2'b01;
        rd_req_addr[0] = 6'h04;
        #1;
        check("t1_ready", 64'(rd_req_ready), 64'h3);
        step();
        rd_req_valid = 2'b00;
        #1;
        check("t1_en", 64'(bank_rd_en), 64'h1);
        check("t1_addr", 64'(bank_rd_addr[0]), 64'h2);
        step();
        #1;
        check("t1_rspv", 64'(rd_rsp_valid), 64'h1);
        check("t1_data", rd_rsp_data[0], 64'hAAAA_0000_0000_0002);
        step();

        // Port 1 read on bank 0 moves the pointer back to 0
        rd_req_valid   = 2'b10;
        rd_req_addr[1] = 6'h04;
        step();
        rd_req_valid = 2'b00;
        step();
        #1;
        check("t1b_rspv", 64'(rd_rsp_valid), 64'h2);
        check("t1b_data", rd_rsp_data[1], 64'hAAAA_0000_0000_0002);
        step();

        conflict("t2a");
        conflict("t2b");

        // Parallel banks 0 and 3
        rd_req_valid   = 2'b11;
        rd_req_addr[0] = 6'h04;
        rd_req_addr[1] = 6'h21;
        step();
        rd_req_valid = 2'b00;
        #1;
        check("t3_en", 64'(bank_rd_en), 64'h9);
        check("t3_addr0", 64'(bank_rd_addr[0]), 64'h2);
        check("t3_addr3", 64'(bank_rd_addr[3]), 64'h0);
        step();
        #1;
        check("t3_rspv", 64'(rd_rsp_valid), 64'h3);
        check("t3_data0", rd_rsp_data[0], 64'hAAAA_0000_0000_0002);
        check("t3_data1", rd_rsp_data[1], 64'hAAAA_0000_0000_0300);
        step();

        // Streaming rows 1, 2, 3 on port 0
        rd_req_valid   = 2'b01;
        rd_req_addr[0] = 6'h02;
        #1;
        check("t4_rdy0", 64'(rd_req_ready[0]), 64'h1);
        step();
        rd_req_addr[0] = 6'h04;
        #1;
        check("t4_rdy1", 64'(rd_req_ready[0]), 64'h1);
        step();
        rd_req_addr[0] = 6'h06;
        #1;
        check("t4_rdy2", 64'(rd_req_ready[0]), 64'h1);
        check("t4_d1", rd_rsp_data[0], 64'hAAAA_0000_0000_0001);
        step();
        rd_req_valid = 2'b00;
        #1;
        check("t4_d2", rd_rsp_data[0], 64'hAAAA_0000_0000_0002);
        step();
        #1;
        check("t4_d3", rd_rsp_data[0], 64'hAAAA_0000_0000_0003);
        step();

        // Fairness on bank 2
        c0 = 0;
        c1 = 0;
        rd_req_valid   = 2'b11;
        rd_req_addr[0] = 6'h07;
        rd_req_addr[1] = 6'h07;
        for (int i = 0; i < 9; i++) begin
            step();
            if (i == 8) rd_req_valid = 2'b00;
            #1;
            if (i >= 1) begin
                c0 += int'(rd_rsp_valid[0]);
                c1 += int'(rd_rsp_valid[1]);
            end
        end
        check("t5_cnt0", 64'(c0), 64'd4);
        check("t5_cnt1", 64'(c1), 64'd4);
        repeat (4) step();

        // Reset while a bank read is in flight; pointer for bank 0 is at 1
        rd_req_valid   = 2'b11;
        rd_req_addr[0] = 6'h04;
        rd_req_addr[1] = 6'h04;
        step();
        rd_req_valid = 2'b00;
        #1;
        check("t6_en", 64'(bank_rd_en), 64'h1);
        check("t6_rdy", 64'(rd_req_ready), 64'h2);
        rst = 1'b1;
        #1;
        check("t6_async_en", 64'(bank_rd_en), 64'h0);
        check("t6_async_rdy", 64'(rd_req_ready), 64'h3);
        step();
        #1;
        check("t6_rspv", 64'(rd_rsp_valid), 64'h0);
        rst = 1'b0;
        step();
        conflict("t6c");
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bank_read_scheduler.md
Name: bank_read_scheduler

Overview:
Read-side counterpart to the per-bank write arbitration in the vector register file. Accepts read requests from PORT_NUM read ports over valid/ready handshakes. Steers each request to one of four 2x2 X/Y banks, resolves bank conflicts with a per-bank round-robin, and issues bank reads. It then routes each bank's 1-cycle-latency read data back to the requesting port as a response pulse.

Parameters:
PORT_NUM, 2, number of read ports
DATA_WIDTH, 64, bank read data width
ADDR_WIDTH, 6, vreg address width; low ADDR_X_WIDTH bits are X, remaining bits are Y
ADDR_X_SIZE, 1, X values below this map to X-low banks
ADDR_X_WIDTH, 1, X field width
ADDR_Y_SIZE, 16, Y values below this map to Y-low banks
ADDR_Y_WIDTH, 4, bank row address width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rd_req_valid  in  [PORT_NUM]  read request valid per port
rd_req_ready  out  [PORT_NUM]  request accepted on edge when valid&ready
rd_req_addr  in  [PORT_NUM][ADDR_WIDTH]  request vreg address
bank_rd_en  out  [4]  bank read strobe
bank_rd_addr  out  [4][ADDR_Y_WIDTH]  bank row address
bank_rd_data  in  [4][DATA_WIDTH]  bank data, valid the cycle after bank_rd_en
rd_rsp_valid  out  [PORT_NUM]  one-cycle response pulse, no backpressure
rd_rsp_data  out  [PORT_NUM][DATA_WIDTH]  response data

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high.
- Bank index = {xh, yh}:
  - xh = ~(addr[ADDR_X_WIDTH-1:0] < ADDR_X_SIZE).
  - yh = ~(addr[ADDR_WIDTH-1:ADDR_X_WIDTH] < ADDR_Y_SIZE).
  - Bank 0 = X low / Y low, 1 = X low / Y high, 2 = X high / Y low, 3 = X high / Y high.
- Row address = addr[ADDR_X_WIDTH +: ADDR_Y_WIDTH]. Every address maps to exactly one bank.
- Per-port pending slot (pend_vld, pend_addr, pend_bank): one outstanding unissued request per port.
- rd_req_ready[p] = ~pend_vld[p] | gnt[p] (combinational). On valid&ready the slot loads the request.
- A request is never arbitrated in its accept cycle.
- The requester holds valid and addr stable while ready is low.
- Per-bank arbitration each cycle, over pending ports whose pend_bank == b:
  - Grant the first such port at or after pointer rr[b], searching modulo PORT_NUM.
  - On a grant, rr[b] <= granted+1 mod PORT_NUM. With no grant, rr[b] holds.
  - Each port hits exactly one bank, so it receives at most one grant per cycle.
- Granted bank b: bank_rd_en[b]=1 and bank_rd_addr[b]=pend_row of the winner.
- Ungranted bank: bank_rd_en[b]=0 and bank_rd_addr[b]=0.
- Granted port's slot clears unless refilled in the same cycle (grant and accept coincide: slot loads the new request).
- Response tags: registered rsp_vld_q[p] <= gnt[p]; rsp_bank_q[p] <= bank granted.
- rd_rsp_valid[p] = rsp_vld_q[p].
- rd_rsp_data[p] = bank_rd_data[rsp_bank_q[p]] when rsp_vld_q[p], else 0.
- Latency: accept at T -> earliest bank_rd_en at T+1 -> rd_rsp_valid at T+2.
- Responses per port return in acceptance order. One accept per port per cycle sustained when uncontended.
- Reset values:
  - pend_vld=0, rsp_vld_q=0, rr[*]=0.
  - Hence rd_req_ready all 1, bank_rd_en 0, bank_rd_addr 0, rd_rsp_valid 0, rd_rsp_data 0.
- Reset mid-operation:
  - Pending requests are dropped.
  - A read issued in the cycle before reset produces no response.
  - The requester must reissue.
- Simultaneous conflicting requests: the loser's ready stays low until it is granted. Worst-case wait is PORT_NUM-1 cycles.

Test Plan:
1. Single read: port0 addr 6'h04 (x=0, y=2) accepted at T -> bank_rd_en=4'b0001, bank_rd_addr[0]=2 at T+1; bank_rd_data[0]=64'hAAAA at T+2 -> rd_rsp_valid=2'b01, rd_rsp_data[0]=64'hAAAA.
2. Conflict: both ports send addr 6'h04 at T with rr[0]=0 -> port0 issues T+1, port1 issues T+2; rd_req_ready[1]=0 at T+1; rr[0]=0 afterwards. A repeated conflict then grants port0 first again, since rr[0] wrapped.
3. Parallel banks: port0 6'h04 (bank0), port1 6'h21 (x=1, y=16, bank3) at T -> bank_rd_en=4'b1001 at T+1; both responses at T+2 with the correct per-bank data.
4. Streaming: port0 valid every cycle with addrs 6'h02, 6'h04, 6'h06 (bank0) -> ready stays 1; responses on three consecutive cycles in order, rows 1, 2, 3.
5. Fairness: both ports request 6'h07 (x=1, y=3, bank2) continuously for 8 cycles -> grants alternate port0/port1, 4 each.
6. Reset: assert rst while bank_rd_en[0]=1 -> rd_rsp_valid stays 0 the next cycle; after release ready=2'b11 and rr reset, so a conflict grants port0 first.
